// File: rtl/lu_acc_pipe.sv
// lu_acc_pipe: registered bitwise logic unit (AND/OR/XOR/NOT) with a
// valid/ready handshake on both sides, an optional accumulator that can
// stand in for operand a, registered zero/parity flags and a wrapping
// count of accepted transactions.
module lu_acc_pipe #(
  parameter int WIDTH  = 8,
  parameter int ACC_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       S,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_parity;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_op_cnt;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_result;
  logic             w_accept;
  op_e              w_op;

  // The accumulator only replaces operand a when it is actually built in.
  assign w_op_a   = ((ACC_EN != 0) && S[2]) ? r_acc : a;
  assign w_op     = op_e'(S[1:0]);

  // Single output register: a new operand fits if the slot is empty or
  // is being drained this very cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Combinational op decode; operand b is ignored for NOT.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_result unassigned,
    // which would otherwise infer a latch.
    w_result = '0;
    case (w_op)
      OP_AND: w_result = w_op_a & b;
      OP_OR:  w_result = w_op_a | b;
      OP_XOR: w_result = w_op_a ^ b;
      OP_NOT: w_result = ~w_op_a;
      default: w_result = '0;
    endcase
  end

  // Output register, flags and transaction counter: load on accept,
  // drop valid on a drain without accept, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      r_y         <= '0;
      r_zero      <= 1'b1;
      r_parity    <= 1'b0;
      r_out_valid <= 1'b0;
      r_op_cnt    <= '0;
    end else if (w_accept) begin
      r_y         <= w_result;
      r_zero      <= (w_result == '0);
      r_parity    <= ^w_result;
      r_out_valid <= 1'b1;
      r_op_cnt    <= r_op_cnt + CNT_W'(1);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  generate
    if (ACC_EN != 0) begin : g_acc
      // Accumulator: clear wins over loading the result on the same edge,
      // while the result itself was already computed from the old value.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_acc <= '0;
        end else if (acc_clr) begin
          r_acc <= '0;
        end else if (w_accept) begin
          r_acc <= w_result;
        end
      end
    end else begin : g_no_acc
      assign r_acc = '0;
    end
  endgenerate

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign parity    = r_parity;
  assign acc       = r_acc;
  assign op_cnt    = r_op_cnt;

endmodule
